vga_stream_ctrl: RTL and testbench
==================================

Name: vga_stream_ctrl

Overview:
- Pixel-domain sequencer for the display read path.
- Owns start-up: waits for the SDRAM-fed async FIFO to fill, then runs the video timing counters and drives HS/VS/BLANK.
- Generates the FIFO read strobe; detects FIFO underflow and re-aligns the stream on a frame boundary.
- Requests a flush/restart of the wishbone-side reader so its pixel address returns to 0.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixel clocks)
- HPULSE, 48, horizontal sync width
- HBP, 40, horizontal back porch
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width
- VBP, 29, vertical back porch

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  reset
- enable  in  1  display enable (pixel domain, level)
- fifo_wfull  in  1  FIFO write-side full flag (wishbone domain, asynchronous to pixel_clk)
- fifo_rempty  in  1  FIFO read-side empty flag (pixel domain)
- fifo_read  out  1  FIFO read strobe; FIFO is show-ahead
- flush_req  out  1  level request to restart the writer at pixel 0 and empty the FIFO
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  high = active pixel (consume FIFO word)
- frame_start  out  1  one-cycle pulse on first active pixel of each frame
- underflow  out  1  sticky error flag
- state_o  out  2  current FSM state (debug)

Behaviour:
- Interface: reset pixel_rst, asynchronous, active-high; clock pixel_clk.
- Reset values:
  - hs=1, vs=1, blank=0, fifo_read=0, frame_start=0, underflow=0, flush_req=1.
  - State IDLE; counters 0; synchroniser flops 0.
- Derived constants:
  - HSUM = HFP+HPULSE+HBP, HTOTAL = HSUM+HDISP.
  - VSUM and VTOTAL likewise.
  - Counter widths are $clog2 of the totals.
- Synchronisation: fifo_wfull passes a 2-flop synchroniser giving wfull_s; 2-cycle latency.
- Counters:
  - pixel_cpt counts 0..HTOTAL-1 and wraps.
  - line_cpt increments on pixel wrap and wraps at VTOTAL-1.
  - Both advance only in RUN and RESYNC. They are held at 0 in IDLE and PRIME.
- Outputs are registered; the value in cycle t+1 is a function of the counters in cycle t:
  - hs = 0 iff HFP <= pixel_cpt < HFP+HPULSE.
  - vs = 0 iff VFP <= line_cpt < VFP+VPULSE.
  - act = (pixel_cpt >= HSUM) && (line_cpt >= VSUM).
  - blank = act in RUN, 0 otherwise.
  - fifo_read = blank (combinational copy of the register).
  - frame_start = 1 when blank rises on counter point (line VSUM, pixel HSUM).
- FSM states:
  - IDLE (00): flush_req=1, sync outputs inactive. Go to PRIME when enable=1.
  - PRIME (01): flush_req=0; wait for wfull_s=1. On wfull_s go to RUN and start counters at 0 the next cycle.
  - RUN (10): normal display.
    - Underflow condition: fifo_read && fifo_rempty in the same cycle. It sets underflow (sticky until reset) and moves to RESYNC.
    - enable=0 is honoured only at frame end (line_cpt=VTOTAL-1, pixel_cpt=HTOTAL-1), then go to IDLE.
  - RESYNC (11): counters and sync pulses keep running; blank=0, fifo_read=0, flush_req=1.
    - At frame end: go to PRIME, counters reset to 0.
    - If enable=0 at that point, go to IDLE instead.
- Simultaneous events:
  - Underflow takes priority over enable=0 at frame end; the next state is RESYNC.
  - wfull_s in RUN/RESYNC is ignored.
- enable dropping in PRIME returns to IDLE immediately.
- pixel_rst mid-frame: all outputs return to reset values asynchronously; no partial-frame state is retained.
- Frame geometry: one frame = HTOTAL*VTOTAL cycles, with exactly HDISP*VDISP fifo_read cycles per frame in RUN.

Decomposition:
- Package vga_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, PRIME, RUN, RESYNC} (2 bits).
  - Default timing localparams.
  - Function computing HSUM/HTOTAL.
- Sub-module sync2: generic 2-flop bit synchroniser with async reset; used for fifo_wfull.

Test Plan:
All scenarios use HDISP=8, VDISP=4, HFP=2, HPULSE=2, HBP=2, VFP=1, VPULSE=1, VBP=1, giving HTOTAL=14, VTOTAL=7, 98 cycles/frame.
- Start-up: enable=1, wfull asserted 10 cycles later -> state RUN exactly 3 cycles after wfull rises; no hs/blank activity before that; flush_req falls 1 cycle after enable.
- Steady frame: fifo_rempty=0 for 3 frames -> exactly 32 fifo_read cycles per 98-cycle frame; hs low 2 cycles per 14; vs low for 14 cycles per frame; frame_start once per frame, coincident with first blank=1.
- Underflow: fifo_rempty=1 during the 5th active pixel -> underflow=1 sticky; blank/fifo_read 0 the next cycle; flush_req=1 until frame end; then PRIME, and RUN again after a new wfull.
- Graceful stop: enable=0 mid-frame -> remaining active pixels of the frame still read; IDLE at frame end; hs=vs=1, blank=0.
- Collision: underflow in the last active pixel while enable=0 -> RESYNC, then IDLE at frame end.
- Async reset during active line -> all outputs at reset values the same cycle; state IDLE; underflow cleared.

Source files
------------

// File: rtl/vga_stream_ctrl_pkg.sv
// vga_ctrl_pkg: shared state encoding and default 800x480 timing for the display read path.
package vga_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, PRIME = 2'b01, RUN = 2'b10, RESYNC = 2'b11} ctrl_state_t;
    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;
    function automatic int tsum(input int fp, input int pulse, input int bp);
        return fp + pulse + bp;
    endfunction
endpackage

// File: rtl/vga_stream_ctrl_if.sv
// vga_stream_ctrl_if: FIFO handshake and video timing signals of the pixel-domain sequencer.
interface vga_stream_ctrl_if;
    logic       enable;
    logic       fifo_wfull;
    logic       fifo_rempty;
    logic       fifo_read;
    logic       flush_req;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame_start;
    logic       underflow;
    logic [1:0] state_o;
    modport master (
        input  enable, fifo_wfull, fifo_rempty,
        output fifo_read, flush_req, hs, vs, blank, frame_start, underflow, state_o
    );
    modport slave (
        output enable, fifo_wfull, fifo_rempty,
        input  fifo_read, flush_req, hs, vs, blank, frame_start, underflow, state_o
    );
endinterface

// File: rtl/vga_stream_ctrl_sync2.sv
// sync2: two-flop single-bit synchroniser with asynchronous reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta, r_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) {r_q, r_meta} <= '0;
        else       {r_q, r_meta} <= {r_meta, i_d};
    assign o_q = r_q;
endmodule

// File: rtl/vga_stream_ctrl.sv
// vga_stream_ctrl: pixel-domain sequencer that primes the display FIFO, runs video timing,
// strobes FIFO reads and re-aligns the stream on a frame boundary after underflow.
module vga_stream_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    vga_stream_ctrl_if.master bus
);
    localparam int HSUM   = tsum(HFP, HPULSE, HBP);
    localparam int HTOTAL = HSUM + HDISP;
    localparam int VSUM   = tsum(VFP, VPULSE, VBP);
    localparam int VTOTAL = VSUM + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    ctrl_state_t   r_state, w_next;
    logic [HW-1:0] r_pix;
    logic [VW-1:0] r_line;
    logic          r_hs, r_vs, r_blank, r_fs, r_uf;
    logic          w_wfull_s, w_counting, w_pix_wrap, w_frame_end, w_uf, w_act, w_hs_win, w_vs_win, w_run_ok;

    sync2 u_sync (.i_clk(pixel_clk), .i_rst(pixel_rst), .i_d(bus.fifo_wfull), .o_q(w_wfull_s));

    assign w_counting  = r_state == RUN || r_state == RESYNC;
    assign w_pix_wrap  = r_pix == HW'(HTOTAL - 1);
    assign w_frame_end = w_pix_wrap && r_line == VW'(VTOTAL - 1);
    assign w_uf        = r_state == RUN && r_blank && bus.fifo_rempty;
    assign w_act       = r_pix >= HW'(HSUM) && r_line >= VW'(VSUM);
    assign w_hs_win    = r_pix >= HW'(HFP) && r_pix < HW'(HFP + HPULSE);
    assign w_vs_win    = r_line >= VW'(VFP) && r_line < VW'(VFP + VPULSE);
    // a read that underflows this cycle suppresses the following pixel immediately
    assign w_run_ok    = r_state == RUN && !w_uf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.enable ? PRIME : IDLE;
            PRIME:   w_next = !bus.enable ? IDLE : w_wfull_s ? RUN : PRIME;
            RUN:     w_next = w_uf ? RESYNC : (w_frame_end && !bus.enable) ? IDLE : RUN;
            RESYNC:  w_next = !w_frame_end ? RESYNC : bus.enable ? PRIME : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            r_state <= IDLE;
            r_pix   <= '0;
            r_line  <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b0;
            r_fs    <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pix   <= (w_counting && !w_pix_wrap) ? r_pix + 1'b1 : '0;
            r_line  <= (!w_counting || w_frame_end) ? '0 : w_pix_wrap ? r_line + 1'b1 : r_line;
            r_hs    <= !(w_counting && w_hs_win);
            r_vs    <= !(w_counting && w_vs_win);
            r_blank <= w_run_ok && w_act;
            r_fs    <= w_run_ok && r_pix == HW'(HSUM) && r_line == VW'(VSUM);
            r_uf    <= r_uf || w_uf;
        end

    assign bus.fifo_read   = r_blank;
    assign bus.blank       = r_blank;
    assign bus.hs          = r_hs;
    assign bus.vs          = r_vs;
    assign bus.frame_start = r_fs;
    assign bus.underflow   = r_uf;
    assign bus.flush_req   = r_state == IDLE || r_state == RESYNC;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_vga_stream_ctrl.sv
// tb_vga_stream_ctrl: directed and randomized checks of vga_stream_ctrl against a
// frame-position reference model on a 14x7 (98-cycle) test geometry.
module tb_vga_stream_ctrl;
    localparam int HD = 8, VD = 4, HF = 2, HP = 2, HB = 2, VF = 1, VP = 1, VB = 1;
    localparam int HS = HF + HP + HB, HT = HS + HD, VS = VF + VP + VB, VT = VS + VD, FR = HT * VT;
    localparam logic [1:0] S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2, S_RESYNC = 2'd3;

    logic pixel_clk = 1'b0;
    logic pixel_rst = 1'b0;
    vga_stream_ctrl_if bus ();

    vga_stream_ctrl #(
        .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB), .VFP(VF), .VPULSE(VP), .VBP(VB)
    ) dut (
        .pixel_clk(pixel_clk),
        .pixel_rst(pixel_rst),
        .bus(bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    // reference model: mode plus a single frame position 0..FR-1
    int   m_mode, m_pos, m_col, m_row;
    logic m_w1, m_w2, m_cnt, m_uf, m_end;
    logic e_hs, e_vs, e_blank, e_fs, e_uf;

    assign m_col = m_pos % HT;
    assign m_row = m_pos / HT;
    assign m_cnt = m_mode == 2 || m_mode == 3;
    assign m_uf  = m_mode == 2 && e_blank && bus.fifo_rempty;
    assign m_end = m_pos == FR - 1;

    always @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            m_mode <= 0; m_pos <= 0; m_w1 <= 1'b0; m_w2 <= 1'b0;
            e_hs <= 1'b1; e_vs <= 1'b1; e_blank <= 1'b0; e_fs <= 1'b0; e_uf <= 1'b0;
        end else begin
            e_hs    <= !(m_cnt && m_col >= HF && m_col < HF + HP);
            e_vs    <= !(m_cnt && m_row >= VF && m_row < VF + VP);
            e_blank <= m_mode == 2 && !m_uf && m_col >= HS && m_row >= VS;
            e_fs    <= m_mode == 2 && !m_uf && m_pos == VS * HT + HS;
            e_uf    <= e_uf || m_uf;
            m_pos   <= m_cnt ? (m_pos + 1) % FR : 0;
            m_w1    <= bus.fifo_wfull;
            m_w2    <= m_w1;
            case (m_mode)
                0: m_mode <= bus.enable ? 1 : 0;
                1: m_mode <= !bus.enable ? 0 : m_w2 ? 2 : 1;
                2: m_mode <= m_uf ? 3 : (m_end && !bus.enable) ? 0 : 2;
                default: m_mode <= !m_end ? 3 : bus.enable ? 1 : 0;
            endcase
        end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int c_rd, c_hs, c_vs, c_fs;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", bus.state_o, 2'(m_mode));
        chk("hs", {1'b0, bus.hs}, {1'b0, e_hs});
        chk("vs", {1'b0, bus.vs}, {1'b0, e_vs});
        chk("blank", {1'b0, bus.blank}, {1'b0, e_blank});
        chk("fifo_read", {1'b0, bus.fifo_read}, {1'b0, e_blank});
        chk("frame_start", {1'b0, bus.frame_start}, {1'b0, e_fs});
        chk("underflow", {1'b0, bus.underflow}, {1'b0, e_uf});
        chk("flush_req", {1'b0, bus.flush_req}, {1'b0, m_mode == 0 || m_mode == 3});
    endtask

    task automatic clear_counts();
        c_rd = 0; c_hs = 0; c_vs = 0; c_fs = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge pixel_clk);
            check_all();
            if (bus.fifo_read) c_rd++;
            if (!bus.hs) c_hs++;
            if (!bus.vs) c_vs++;
            if (bus.frame_start) c_fs++;
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin step(1); k++; end while (!bus.frame_start && k < 300);
        chk("wait_frame_start", {1'b0, bus.frame_start}, 2'b01);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int k = 0;
        do begin step(1); k++; end while (bus.state_o !== s && k < 300);
        chk(tag, bus.state_o, s);
    endtask

    initial begin
        int d;
        bus.enable = 1'b0; bus.fifo_wfull = 1'b0; bus.fifo_rempty = 1'b0;
        #1 pixel_rst = 1'b1;
        #1 check_all();
        chk("rst_flush", {1'b0, bus.flush_req}, 2'b01);
        chk("rst_hs", {1'b0, bus.hs}, 2'b01);
        chk("rst_state", bus.state_o, S_IDLE);
        step(3);
        pixel_rst = 1'b0;
        step(2);

        // start-up
        bus.enable = 1'b1;
        step(1);
        chk("flush_fall", {1'b0, bus.flush_req}, 2'b00);
        chk("prime", bus.state_o, S_PRIME);
        step(9);
        bus.fifo_wfull = 1'b1;
        step(2);
        chk("prime_hold", bus.state_o, S_PRIME);
        chk("no_hs_early", {1'b0, bus.hs}, 2'b01);
        step(1);
        chk("run_latency", bus.state_o, S_RUN);

        // steady frames
        wait_fs();
        chk("fs_with_blank", {1'b0, bus.blank}, 2'b01);
        step(97);
        for (int f = 0; f < 3; f++) begin
            clear_counts();
            step(FR);
            chk("reads_per_frame", 2'(c_rd == HD * VD), 2'd1);
            chk("hs_low_per_frame", 2'(c_hs == HP * VT), 2'd1);
            chk("vs_low_per_frame", 2'(c_vs == VP * HT), 2'd1);
            chk("fs_per_frame", 2'(c_fs == 1), 2'd1);
        end

        // underflow on the 5th active pixel
        wait_fs();
        step(4);
        bus.fifo_rempty = 1'b1;
        step(1);
        bus.fifo_rempty = 1'b0;
        bus.fifo_wfull = 1'b0;
        chk("uf_flag", {1'b0, bus.underflow}, 2'b01);
        chk("uf_read_off", {1'b0, bus.fifo_read}, 2'b00);
        chk("uf_resync", bus.state_o, S_RESYNC);
        wait_state(S_PRIME, "resync_to_prime");
        chk("uf_sticky", {1'b0, bus.underflow}, 2'b01);
        d = $urandom_range(3, 15);
        step(d);
        chk("prime_wait_wfull", bus.state_o, S_PRIME);
        bus.fifo_wfull = 1'b1;
        step(2);
        chk("prime_before_sync", bus.state_o, S_PRIME);
        step(1);
        chk("rerun", bus.state_o, S_RUN);

        // graceful stop mid-frame
        wait_fs();
        clear_counts();
        step($urandom_range(5, 40));
        bus.enable = 1'b0;
        wait_state(S_IDLE, "stop_to_idle");
        chk("stop_reads", 2'(c_rd == HD * VD - 1), 2'd1);
        step(1);
        chk("idle_hs", {1'b0, bus.hs}, 2'b01);
        chk("idle_vs", {1'b0, bus.vs}, 2'b01);
        chk("idle_blank", {1'b0, bus.blank}, 2'b00);

        // underflow at frame end while enable is low
        bus.enable = 1'b1;
        wait_state(S_RUN, "collision_run");
        wait_fs();
        bus.enable = 1'b0;
        step(FR - VS * HT - HS - 2);
        chk("last_read", {1'b0, bus.fifo_read}, 2'b01);
        bus.fifo_rempty = 1'b1;
        step(1);
        bus.fifo_rempty = 1'b0;
        chk("collision_resync", bus.state_o, S_RESYNC);
        wait_state(S_IDLE, "collision_idle");

        // randomized soak
        bus.enable = 1'b1;
        bus.fifo_wfull = 1'b1;
        for (int i = 0; i < 800; i++) begin
            bus.fifo_rempty = $urandom_range(0, 49) == 0;
            if ($urandom_range(0, 199) == 0) bus.enable = !bus.enable;
            if ($urandom_range(0, 99) == 0) bus.fifo_wfull = !bus.fifo_wfull;
            step(1);
        end

        // asynchronous reset in the middle of an active line
        bus.enable = 1'b1; bus.fifo_wfull = 1'b1; bus.fifo_rempty = 1'b0;
        wait_state(S_RUN, "pre_rst_run");
        wait_fs();
        step(2);
        chk("pre_rst_blank", {1'b0, bus.blank}, 2'b01);
        #2 pixel_rst = 1'b1;
        #1 check_all();
        chk("arst_state", bus.state_o, S_IDLE);
        chk("arst_blank", {1'b0, bus.blank}, 2'b00);
        chk("arst_read", {1'b0, bus.fifo_read}, 2'b00);
        chk("arst_uf", {1'b0, bus.underflow}, 2'b00);
        chk("arst_flush", {1'b0, bus.flush_req}, 2'b01);
        chk("arst_hs_vs", {bus.hs, bus.vs}, 2'b11);
        step(2);
        pixel_rst = 1'b0;
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
